// File: rtl/hilihase_mon_pkg.sv
// Shared types and constants for the signal-change monitor and its event FIFO.
package hilihase_mon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } mon_state_e;

    localparam int DEF_NUM_SIG = 8;
    localparam int DEF_TS_W    = 32;
    localparam int DEF_DEPTH   = 16;
    localparam int LVL_W       = $clog2(DEF_DEPTH) + 1;

    // Event layout at the default widths; the top re-declares it with its own parameters.
    typedef struct packed {
        logic [DEF_TS_W-1:0]    ts;
        logic [DEF_NUM_SIG-1:0] mask;
        logic [DEF_NUM_SIG-1:0] value;
    } ev_entry_t;

    function automatic int lvl_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/hilihase_ev_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy output and synchronous flush.
module hilihase_ev_fifo
    import hilihase_mon_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // The extra pointer bit separates full from empty when the index bits match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/hilihase_sig_monitor.sv
// Samples observed DUT signals each clock and queues timestamped change events for the co-sim host.
module hilihase_sig_monitor
    import hilihase_mon_pkg::*;
#(
    parameter int NUM_SIG = 8,
    parameter int TS_W    = 32,
    parameter int DEPTH   = 16,
    parameter int DROP_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   flush,
    input  logic [NUM_SIG-1:0]     sig_in,
    output logic                   ev_valid,
    input  logic                   ev_ready,
    output logic [TS_W-1:0]        ev_ts,
    output logic [NUM_SIG-1:0]     ev_mask,
    output logic [NUM_SIG-1:0]     ev_value,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic [DROP_W-1:0]      drop_cnt
);

    typedef struct packed {
        logic [TS_W-1:0]    ts;
        logic [NUM_SIG-1:0] mask;
        logic [NUM_SIG-1:0] value;
    } mon_entry_t;

    localparam int EW = $bits(mon_entry_t);

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + {{(DROP_W-1){1'b0}}, 1'b1};
    endfunction

    mon_state_e         state;
    logic [TS_W-1:0]    ts_q;
    logic [NUM_SIG-1:0] prev_q;
    logic [NUM_SIG-1:0] change;
    logic               push_req;
    mon_entry_t         push_ent;
    mon_entry_t         head;
    logic               fifo_empty;
    logic               fifo_full;
    logic               pop;
    logic               drop;

    assign change = sig_in ^ prev_q;

    // ARM always emits a full-mask baseline; RUN emits only on change and never on its exit edge.
    always_comb begin
        push_req       = 1'b0;
        push_ent.ts    = ts_q;
        push_ent.mask  = '1;
        push_ent.value = sig_in;
        case (state)
            ARM: push_req = 1'b1;
            RUN: begin
                push_req      = en && (|change);
                push_ent.mask = change;
            end
            default: push_req = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ts_q   <= '0;
            prev_q <= '0;
        end else begin
            if (state != IDLE) ts_q <= ts_q + 1'b1;
            case (state)
                IDLE: if (en) state <= ARM;
                ARM: begin
                    prev_q <= sig_in;
                    state  <= en ? RUN : IDLE;
                end
                RUN: begin
                    prev_q <= sig_in;
                    if (!en) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign pop  = ev_valid && ev_ready;
    assign drop = push_req && fifo_full && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (flush) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            drop_cnt <= sat_inc(drop_cnt);
        end
    end

    hilihase_ev_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (push_req),
        .din   (push_ent),
        .pop   (pop),
        .dout  (head),
        .empty (fifo_empty),
        .full  (fifo_full),
        .level (level)
    );

    // Head fields read as zero when nothing is queued, hiding uninitialised storage.
    assign ev_valid = !fifo_empty;
    assign ev_ts    = ev_valid ? head.ts    : '0;
    assign ev_mask  = ev_valid ? head.mask  : '0;
    assign ev_value = ev_valid ? head.value : '0;

endmodule

// File: tb/tb_hilihase_sig_monitor.sv
// Directed bench for hilihase_sig_monitor: baseline, changes, backpressure, overflow, flush, enable and reset.
module tb_hilihase_sig_monitor;

    localparam int NUM_SIG = 8;
    localparam int TS_W    = 32;
    localparam int DEPTH   = 16;
    localparam int DROP_W  = 16;
    localparam int LW      = $clog2(DEPTH) + 1;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               en;
    logic               flush;
    logic [NUM_SIG-1:0] sig_in;
    logic               ev_valid;
    logic               ev_ready;
    logic [TS_W-1:0]    ev_ts;
    logic [NUM_SIG-1:0] ev_mask;
    logic [NUM_SIG-1:0] ev_value;
    logic [LW-1:0]      level;
    logic               overflow;
    logic [DROP_W-1:0]  drop_cnt;

    int vectors = 0;
    int errors  = 0;

    hilihase_sig_monitor #(
        .NUM_SIG (NUM_SIG),
        .TS_W    (TS_W),
        .DEPTH   (DEPTH),
        .DROP_W  (DROP_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .flush    (flush),
        .sig_in   (sig_in),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .ev_ts    (ev_ts),
        .ev_mask  (ev_mask),
        .ev_value (ev_value),
        .level    (level),
        .overflow (overflow),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_head(input string tag, input logic [31:0] ts, input logic [7:0] mask,
                              input logic [7:0] value, input int lvl);
        check({tag, ".valid"}, 64'(ev_valid), 64'd1);
        check({tag, ".ts"},    64'(ev_ts),    64'(ts));
        check({tag, ".mask"},  64'(ev_mask),  64'(mask));
        check({tag, ".value"}, 64'(ev_value), 64'(value));
        check({tag, ".level"}, 64'(level),    64'(lvl));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".valid"},    64'(ev_valid), 64'd0);
        check({tag, ".ts"},       64'(ev_ts),    64'd0);
        check({tag, ".mask"},     64'(ev_mask),  64'd0);
        check({tag, ".value"},    64'(ev_value), 64'd0);
        check({tag, ".level"},    64'(level),    64'd0);
        check({tag, ".overflow"}, 64'(overflow), 64'd0);
        check({tag, ".drop_cnt"}, 64'(drop_cnt), 64'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        flush    = 1'b0;
        sig_in   = 8'hA5;
        ev_ready = 1'b0;
        #3;
        check_idle_outputs("reset");
        tick();
        rst_n = 1'b1;

        // Baseline: IDLE->ARM at ts=0, baseline pushed on the ARM edge.
        en = 1'b1;
        tick();
        check("arm.valid", 64'(ev_valid), 64'd0);
        tick();
        check_head("baseline", 32'd0, 8'hFF, 8'hA5, 1);
        ev_ready = 1'b1;
        tick();                                  // ts=1, pops baseline
        ev_ready = 1'b0;
        check("pop_base.valid", 64'(ev_valid), 64'd0);
        tick(); tick(); tick();                  // ts=2..4, static input
        check("static.level", 64'(level), 64'd0);

        // Two bits flip together at ts=5 -> one entry.
        sig_in = 8'h24;
        tick();
        check_head("multi", 32'd5, 8'h81, 8'h24, 1);

        // Queue two more entries, then hold off the consumer.
        sig_in = 8'h25;
        tick();                                  // ts=6
        sig_in = 8'hA5;
        tick();                                  // ts=7
        for (int i = 0; i < 10; i++) begin
            tick();
            check_head("stall", 32'd5, 8'h81, 8'h24, 3);
        end
        ev_ready = 1'b1;
        tick();
        check_head("drain1", 32'd6, 8'h01, 8'h25, 2);
        tick();
        check_head("drain2", 32'd7, 8'h80, 8'hA5, 1);
        tick();
        check("drain3.level", 64'(level), 64'd0);
        check("drain3.valid", 64'(ev_valid), 64'd0);
        ev_ready = 1'b0;

        // Overflow: 20 changes at ts=21..40, 16 kept, 4 dropped.
        for (int i = 0; i < 20; i++) begin
            sig_in = sig_in ^ 8'h01;
            tick();
        end
        check_head("full", 32'd21, 8'h01, 8'hA4, 16);
        check("full.overflow", 64'(overflow), 64'd1);
        check("full.drop_cnt", 64'(drop_cnt), 64'd4);

        // Push with simultaneous pop while full is accepted.
        sig_in   = 8'hA4;
        ev_ready = 1'b1;
        tick();                                  // ts=41
        ev_ready = 1'b0;
        check_head("full_pp", 32'd22, 8'h01, 8'hA5, 16);
        check("full_pp.drop_cnt", 64'(drop_cnt), 64'd4);

        // Flush at ts=42; its change is lost, timestamp keeps running.
        flush  = 1'b1;
        sig_in = 8'hA5;
        tick();
        flush = 1'b0;
        check("flush.level",    64'(level),    64'd0);
        check("flush.valid",    64'(ev_valid), 64'd0);
        check("flush.overflow", 64'(overflow), 64'd0);
        check("flush.drop_cnt", 64'(drop_cnt), 64'd0);
        tick();                                  // ts=43, static
        check("post_flush.level", 64'(level), 64'd0);
        sig_in = 8'hA4;
        tick();                                  // ts=44
        check_head("post_flush", 32'd44, 8'h01, 8'hA4, 1);

        // Drop enable with entries queued; timestamp freezes, draining continues.
        sig_in = 8'hA5;
        tick();                                  // ts=45
        en = 1'b0;
        tick();                                  // RUN->IDLE, ts becomes 47
        sig_in = 8'h00;
        tick();
        check("idle.level", 64'(level), 64'd2);
        ev_ready = 1'b1;
        tick();
        check_head("idle_drain", 32'd45, 8'h01, 8'hA5, 1);
        tick();
        check("idle_drain.valid", 64'(ev_valid), 64'd0);
        ev_ready = 1'b0;
        en     = 1'b1;
        sig_in = 8'h3C;
        tick();
        tick();
        check_head("rearm", 32'd47, 8'hFF, 8'h3C, 1);

        // Asynchronous reset mid-drain.
        sig_in = 8'h3D;
        tick();                                  // ts=48
        check("pre_rst.level", 64'(level), 64'd2);
        ev_ready = 1'b1;
        tick();
        check_head("pre_rst", 32'd48, 8'h01, 8'h3D, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        tick();
        rst_n    = 1'b1;
        ev_ready = 1'b0;
        en       = 1'b0;
        tick();
        check("after_rst.level", 64'(level), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
